// File: rtl/alu_seq_param.sv
// Signed multi-cycle ALU: ADD/SUB/logic in one cycle, shift-add MUL and restoring DIV over WIDTH iterations.
// start is honoured only in IDLE; done pulses once per accepted op, with result/err_code registered on that cycle.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [1:0]         err_code
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t state, state_nxt;

  // hi/lo: partial product for MUL, remainder/quotient-shift pair for DIV
  logic [WIDTH-1:0] hi, lo, opb;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r;
  logic [1:0]       err_pend;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf, multi;
  logic [WIDTH:0]     sum_add, sum_sub;
  logic [2*WIDTH-1:0] quick_res;
  logic [1:0]         quick_err;

  assign a_mag    = in_a[WIDTH-1] ? -in_a : in_a;
  assign b_mag    = in_b[WIDTH-1] ? -in_b : in_b;
  assign div_zero = (op == OP_DIV) && (in_b == '0);
  assign div_ovf  = (op == OP_DIV) && (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == '1);
  assign multi    = (op == OP_MUL) || ((op == OP_DIV) && !div_zero);
  assign sum_add  = {in_a[WIDTH-1], in_a} + {in_b[WIDTH-1], in_b};
  assign sum_sub  = {in_a[WIDTH-1], in_a} - {in_b[WIDTH-1], in_b};

  always_comb begin
    quick_res = '0;
    quick_err = 2'b00;
    case (op)
      OP_ADD:  quick_res = {{(WIDTH-1){sum_add[WIDTH]}}, sum_add};
      OP_SUB:  quick_res = {{(WIDTH-1){sum_sub[WIDTH]}}, sum_sub};
      OP_AND:  quick_res = {{WIDTH{1'b0}}, in_a & in_b};
      OP_OR:   quick_res = {{WIDTH{1'b0}}, in_a | in_b};
      OP_XOR:  quick_res = {{WIDTH{1'b0}}, in_a ^ in_b};
      OP_DIV:  quick_err = 2'b01;
      OP_MUL:  quick_err = 2'b00;
      default: quick_err = 2'b11;
    endcase
  end

  // One iteration of either algorithm; remainder < divisor keeps both in WIDTH bits
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  assign mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opb : {WIDTH{1'b0}})};
  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  always_comb begin
    hi_nxt = mul_sum[WIDTH:1];
    lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      hi_nxt = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end
  end

  logic [2*WIDTH-1:0] prod, mul_fix, div_fix;
  assign prod    = {hi, lo};
  assign mul_fix = neg_q ? -prod : prod;
  assign div_fix = {(neg_r ? -hi : hi), (neg_q ? -lo : lo)};

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = multi ? S_CALC : S_DONE;
      S_CALC:  if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      result   <= '0;
      err_code <= 2'b00;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      err_pend <= 2'b00;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          is_div   <= (op == OP_DIV);
          neg_q    <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
          neg_r    <= in_a[WIDTH-1];
          err_pend <= div_ovf ? 2'b10 : 2'b00;
          cnt      <= '0;
          if (multi) begin
            hi  <= '0;
            lo  <= a_mag;
            opb <= b_mag;
          end else begin
            result   <= quick_res;
            err_code <= quick_err;
          end
        end
        S_CALC: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          result   <= is_div ? div_fix : mul_fix;
          err_code <= err_pend;
        end
        default: ;
      endcase
    end
  end
endmodule
